// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN output stages.
// Holds datapath geometry (hidden length, word width, fraction bits,
// accumulator width), the memory bank select codes, the saturation limits
// of the signed Q4.16 output word and the controller state encoding.
package rnn_pkg;

    localparam int HID   = 64;                            // hidden vector length
    localparam int DW    = 20;                            // signed Q4.16 word
    localparam int TW    = 11;                            // timestep index width
    localparam int FRAC  = 16;                            // fraction bits of a word
    localparam int ACC_W = 2 * DW + $clog2(HID) + 1;      // 47: 64 products never wrap

    localparam logic [2:0] MSEL_HID  = 3'b101;
    localparam logic [2:0] MSEL_WOUT = 3'b110;
    localparam logic [2:0] MSEL_BOUT = 3'b111;

    localparam logic signed [DW-1:0] SAT_MAX = 20'sh7FFFF;
    localparam logic signed [DW-1:0] SAT_MIN = 20'sh80000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_B = 3'd2,
        MAC    = 3'd3,
        FINAL  = 3'd4,
        OUT    = 3'd5
    } state_t;

endpackage

// File: rtl/rnn_round_sat.sv
// Rounding and saturation of a wide accumulator back to a Q4.16 word.
// The accumulator carries 32 fraction bits; the low 16 are dropped with
// round-half-away-from-zero (decided at bit 15), then the result is
// clamped to the signed 20-bit range.
// Ports:
//   din  in  ACC_W  signed accumulator value (Q.32)
//   dout out DW     rounded, saturated signed Q4.16 result
module rnn_round_sat
    import rnn_pkg::*;
(
    input  logic [ACC_W-1:0] din,
    output logic [DW-1:0]    dout
);

    // One guard bit so the rounding increment can never overflow.
    localparam int EW = ACC_W + 1;
    localparam logic signed [EW-1:0] HALF = EW'(1'b1) << (FRAC - 1);
    localparam logic signed [EW-1:0] MAXV = EW'(SAT_MAX);
    localparam logic signed [EW-1:0] MINV = EW'(SAT_MIN);

    logic signed [EW-1:0] ext_s;
    logic signed [EW-1:0] rnd_s;
    logic signed [EW-1:0] q_s;

    // Round half away from zero, shift down to Q4.16, then clamp.
    always_comb begin
        ext_s = EW'($signed(din));
        // Negative values add one less than half so that an exact -0.5
        // still moves away from zero after the flooring shift.
        if (ext_s[EW-1]) begin
            rnd_s = ext_s + HALF - EW'(1'b1);
        end else begin
            rnd_s = ext_s + HALF;
        end
        q_s = rnd_s >>> FRAC;
        if (q_s > MAXV) begin
            dout = SAT_MAX;
        end else if (q_s < MINV) begin
            dout = SAT_MIN;
        end else begin
            dout = q_s[DW-1:0];
        end
    end

endmodule

// File: rtl/rnn_out_proj.sv
// RNN output projection: y_t = round_sat(sum_h w[h]*hid[t][h] + bias)
// for t = 0..t_last. Weights and bias are preloaded once per start into a
// local register file; each timestep then streams 64 hidden values.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   ready    in   start request (IDLE only); t_last sampled with it
//   t_last   in   last timestep index
//   busy     out  operation in progress
//   mce      out  memory read enable
//   msel     out  bank select (101 hidden, 110 weights, 111 bias)
//   maddr    out  read address ({t,h} / h / 0)
//   mdata_r  in   read data, valid the cycle after the request
//   o_valid  out  output word valid, held until o_ready
//   o_ready  in   output accept
//   o_data   out  projected output y_t (Q4.16)
//   o_addr   out  timestep index of o_data
module rnn_out_proj #(
    parameter int HID = rnn_pkg::HID,
    parameter int DW  = rnn_pkg::DW,
    parameter int TW  = rnn_pkg::TW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready,
    input  logic [TW-1:0]              t_last,
    output logic                       busy,
    output logic                       mce,
    output logic [2:0]                 msel,
    output logic [TW+$clog2(HID)-1:0]  maddr,
    input  logic [DW-1:0]              mdata_r,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DW-1:0]              o_data,
    output logic [TW-1:0]              o_addr
);

    import rnn_pkg::*;

    localparam int HW = $clog2(HID);
    localparam int CW = HW + 1;
    localparam int AW = TW + HW;
    localparam int PW = 2 * DW;

    state_t               state_r, state_n;
    logic [CW-1:0]        cnt_r, cnt_n;        // read index being issued
    logic [TW-1:0]        t_r, t_n;
    logic [TW-1:0]        t_last_r;
    logic signed [DW-1:0] wfile_r [HID];
    logic signed [DW-1:0] bias_r;
    logic signed [ACC_W-1:0] acc_r;

    logic [HW-1:0]        widx_s;
    logic                 w_we_s;
    logic signed [PW-1:0] prod_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [DW-1:0]        rs_s;
    logic                 mce_s;
    logic [2:0]           msel_s;
    logic [AW-1:0]        maddr_s;

    // State, counter and timestep registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            t_r     <= {TW{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            t_r     <= t_n;
        end
    end

    // Next-state, read counter and timestep sequencing.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        t_n     = t_r;
        case (state_r)
            IDLE: begin
                if (ready) begin
                    state_n = LOAD_W;
                    cnt_n   = {CW{1'b0}};
                    t_n     = {TW{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD_W: begin
                if (cnt_r == CW'(HID - 1)) begin
                    state_n = LOAD_B;
                    cnt_n   = {CW{1'b0}};
                end else begin
                    cnt_n   = cnt_r + CW'(1'b1);
                end
            end
            // Two cycles: issue the bias read, then wait for its data.
            LOAD_B: begin
                if (cnt_r == CW'(1'b1)) begin
                    state_n = MAC;
                    cnt_n   = {CW{1'b0}};
                end else begin
                    cnt_n   = cnt_r + CW'(1'b1);
                end
            end
            // cnt 0..HID-1 issue hidden reads, cnt == HID is the drain cycle.
            MAC: begin
                if (cnt_r == CW'(HID)) begin
                    state_n = FINAL;
                    cnt_n   = {CW{1'b0}};
                end else begin
                    cnt_n   = cnt_r + CW'(1'b1);
                end
            end
            FINAL: begin
                state_n = OUT;
            end
            OUT: begin
                if (o_ready) begin
                    if (t_r == t_last_r) begin
                        state_n = IDLE;
                    end else begin
                        state_n = MAC;
                        cnt_n   = {CW{1'b0}};
                        t_n     = t_r + TW'(1'b1);
                    end
                end else begin
                    state_n = OUT;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {CW{1'b0}};
                t_n     = {TW{1'b0}};
            end
        endcase
    end

    // Memory request decode from the upcoming state, so the registered
    // request lines line up with the state that issues them.
    always_comb begin
        mce_s   = 1'b0;
        msel_s  = 3'b000;
        maddr_s = {AW{1'b0}};
        case (state_n)
            LOAD_W: begin
                mce_s   = 1'b1;
                msel_s  = MSEL_WOUT;
                maddr_s = AW'(cnt_n[HW-1:0]);
            end
            LOAD_B: begin
                if (cnt_n == {CW{1'b0}}) begin
                    mce_s   = 1'b1;
                    msel_s  = MSEL_BOUT;
                    maddr_s = {AW{1'b0}};
                end else begin
                    mce_s   = 1'b0;
                    msel_s  = 3'b000;
                    maddr_s = {AW{1'b0}};
                end
            end
            MAC: begin
                if (cnt_n < CW'(HID)) begin
                    mce_s   = 1'b1;
                    msel_s  = MSEL_HID;
                    maddr_s = {t_n, cnt_n[HW-1:0]};
                end else begin
                    mce_s   = 1'b0;
                    msel_s  = 3'b000;
                    maddr_s = {AW{1'b0}};
                end
            end
            default: begin
                mce_s   = 1'b0;
                msel_s  = 3'b000;
                maddr_s = {AW{1'b0}};
            end
        endcase
    end

    // Registered control and memory request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            mce     <= 1'b0;
            msel    <= 3'b000;
            maddr   <= {AW{1'b0}};
            o_valid <= 1'b0;
        end else begin
            busy    <= (state_n != IDLE);
            mce     <= mce_s;
            msel    <= msel_s;
            maddr   <= maddr_s;
            o_valid <= (state_n == OUT);
        end
    end

    // Datapath helpers: data arriving now belongs to the read issued one
    // cycle earlier, hence index cnt-1 (wraps to HID-1 for the drain and
    // for the last weight landing in the first LOAD_B cycle).
    always_comb begin
        widx_s = cnt_r[HW-1:0] - HW'(1'b1);
        w_we_s = ((state_r == LOAD_W) && (cnt_r != {CW{1'b0}})) ||
                 ((state_r == LOAD_B) && (cnt_r == {CW{1'b0}}));
        prod_s = wfile_r[widx_s] * $signed(mdata_r);
        sum_s  = acc_r + (ACC_W'(bias_r) <<< FRAC);
    end

    // Weight register file; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_we_s) begin
            wfile_r[widx_s] <= mdata_r;
        end
    end

    // Accumulator, bias, latched t_last and output word registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_last_r <= {TW{1'b0}};
            bias_r   <= {DW{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            o_data   <= {DW{1'b0}};
            o_addr   <= {TW{1'b0}};
        end else begin
            if ((state_r == IDLE) && ready) begin
                t_last_r <= t_last;
            end
            if ((state_r == LOAD_B) && (cnt_r == CW'(1'b1))) begin
                bias_r <= mdata_r;
            end
            if (state_r == MAC) begin
                if (cnt_r == {CW{1'b0}}) begin
                    acc_r <= {ACC_W{1'b0}};
                end else begin
                    acc_r <= acc_r + ACC_W'(prod_s);
                end
            end
            if (state_r == FINAL) begin
                o_data <= rs_s;
                o_addr <= t_r;
            end
        end
    end

    rnn_round_sat u_round_sat (
        .din  (sum_s),
        .dout (rs_s)
    );

endmodule

// File: tb/tb_rnn_out_proj.sv
// Directed self-checking bench for rnn_out_proj with a behavioural
// one-cycle-latency memory holding weights, bias and hidden states.
module tb_rnn_out_proj;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [10:0] t_last;
    logic        busy;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_r = 20'h00000;
    logic        o_valid;
    logic        o_ready;
    logic [19:0] o_data;
    logic [10:0] o_addr;

    logic [19:0] wmem [64];
    logic [19:0] hmem [131072];
    logic [19:0] bmem;

    int checks = 0;
    int errors = 0;
    int reads  = 0;
    int viol   = 0;
    int rd0    = 0;
    int jc     = 0;

    always #5 clk = ~clk;

    rnn_out_proj dut (
        .clk     (clk),
        .reset   (reset),
        .ready   (ready),
        .t_last  (t_last),
        .busy    (busy),
        .mce     (mce),
        .msel    (msel),
        .maddr   (maddr),
        .mdata_r (mdata_r),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_addr  (o_addr)
    );

    // Memory model: data for a request appears after the next rising edge.
    always @(posedge clk) begin
        if (mce) begin
            case (msel)
                3'b101:  mdata_r <= hmem[maddr];
                3'b110:  mdata_r <= wmem[maddr[5:0]];
                3'b111:  mdata_r <= bmem;
                default: mdata_r <= 20'hABCDE;
            endcase
        end
    end

    // Protocol monitor: read counting and idle-bus / OUT-quiet rules.
    always @(posedge clk) begin
        if (reset) begin
            if (mce) reads <= reads + 1;
            if ((!mce && (msel != 3'b000 || maddr != 17'd0)) ||
                (mce && (o_valid || msel < 3'b101)))
                viol <= viol + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        jc++;
    endtask

    task automatic fill(input logic [19:0] wv, input logic [19:0] hv, input logic [19:0] bv);
        for (int i = 0; i < 64; i++) begin
            wmem[i] = wv;
            for (int t = 0; t < 4; t++) hmem[t * 64 + i] = hv;
        end
        bmem = bv;
    endtask

    // Called at a negedge; the following rising edge is the start edge.
    task automatic start_run(input logic [10:0] tl);
        t_last = tl;
        ready  = 1'b1;
        rd0    = reads;
        @(negedge clk);
        jc     = 1;
        ready  = 1'b0;
        t_last = 11'd0;
    endtask

    task automatic wait_valid(input string tag, input int exp_j);
        while (!o_valid && jc < 2000) tick();
        chk({tag, "_lat"}, 64'(jc), 64'(exp_j));
    endtask

    task automatic run_one(input string tag, input logic [19:0] expv);
        start_run(11'd0);
        wait_valid(tag, 133);
        chk({tag, "_data"}, 64'(o_data), 64'(expv));
        chk({tag, "_addr"}, 64'(o_addr), 64'd0);
        tick();
        chk({tag, "_done"}, 64'({busy, o_valid}), 64'd0);
        chk({tag, "_reads"}, 64'(reads - rd0), 64'd129);
    endtask

    initial begin
        reset   = 1'b0;
        ready   = 1'b0;
        o_ready = 1'b0;
        t_last  = 11'd0;
        fill(20'h00000, 20'h00000, 20'h00000);
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({busy, mce, msel, maddr, o_valid}), 64'd0);
        chk("rst_out", 64'({o_data, o_addr}), 64'd0);
        reset   = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);

        // Unit weights, hidden 2^-8, one timestep; also checks read schedule.
        fill(20'h10000, 20'h00100, 20'h00000);
        start_run(11'd0);
        chk("a_busy1", 64'(busy), 64'd1);
        chk("a_rd_w0", 64'({mce, msel, maddr}), 64'({1'b1, 3'b110, 17'd0}));
        tick();
        chk("a_rd_w1", 64'({mce, msel, maddr}), 64'({1'b1, 3'b110, 17'd1}));
        while (jc < 65) tick();
        chk("a_rd_b", 64'({mce, msel, maddr}), 64'({1'b1, 3'b111, 17'd0}));
        tick();
        chk("a_gap", 64'({mce, msel, maddr}), 64'd0);
        tick();
        chk("a_rd_h0", 64'({mce, msel, maddr}), 64'({1'b1, 3'b101, 17'd0}));
        wait_valid("a", 133);
        chk("a_data", 64'(o_data), 64'h04000);
        chk("a_addr", 64'(o_addr), 64'd0);
        tick();
        chk("a_done", 64'({busy, o_valid}), 64'd0);
        chk("a_reads", 64'(reads - rd0), 64'd129);

        // Saturation both ways.
        fill(20'h70000, 20'h70000, 20'h00000);
        run_one("sat_pos", 20'h7FFFF);
        fill(20'h90000, 20'h70000, 20'h00000);
        run_one("sat_neg", 20'h80000);

        // Rounding at bit 15, half away from zero.
        fill(20'h00000, 20'h00000, 20'h00000);
        wmem[0] = 20'h00001;
        hmem[0] = 20'h08000;
        run_one("rnd_up", 20'h00001);
        wmem[0] = 20'hFFFFF;
        run_one("rnd_neg", 20'hFFFFF);
        wmem[0] = 20'h00001;
        hmem[0] = 20'h07FFF;
        run_one("rnd_dn", 20'h00000);

        // Bias alone, then first/last index alignment.
        fill(20'h00000, 20'h00000, 20'h00001);
        run_one("bias", 20'h00001);
        fill(20'h00000, 20'h00000, 20'h00000);
        wmem[1]  = 20'h10000;
        hmem[1]  = 20'h00005;
        wmem[63] = 20'h10000;
        hmem[63] = 20'h00123;
        run_one("index", 20'h00128);

        // Three timesteps back to back with o_ready high.
        fill(20'h10000, 20'h00100, 20'h00000);
        for (int i = 0; i < 64; i++) begin
            hmem[64 + i]  = 20'h00200;
            hmem[128 + i] = 20'hFFF00;
        end
        start_run(11'd2);
        wait_valid("m0", 133);
        chk("m0_data", 64'({o_addr, o_data}), 64'({11'd0, 20'h04000}));
        tick();
        chk("m0_drop", 64'(o_valid), 64'd0);
        wait_valid("m1", 200);
        chk("m1_data", 64'({o_addr, o_data}), 64'({11'd1, 20'h08000}));
        tick();
        wait_valid("m2", 267);
        chk("m2_data", 64'({o_addr, o_data, busy}), 64'({11'd2, 20'hFC000, 1'b1}));
        tick();
        chk("m_done", 64'(busy), 64'd0);
        chk("m_reads", 64'(reads - rd0), 64'd257);

        // Back-pressure: hold o_ready low five cycles; ready pulsed meanwhile.
        o_ready = 1'b0;
        start_run(11'd1);
        wait_valid("bp0", 133);
        chk("bp0_data", 64'({o_addr, o_data}), 64'({11'd0, 20'h04000}));
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold", 64'({o_valid, mce, o_addr, o_data}),
                64'({1'b1, 1'b0, 11'd0, 20'h04000}));
        end
        ready   = 1'b0;
        o_ready = 1'b1;
        tick();
        chk("bp_rel", 64'(o_valid), 64'd0);
        wait_valid("bp1", 205);
        chk("bp1_data", 64'({o_addr, o_data}), 64'({11'd1, 20'h08000}));
        tick();
        chk("bp_done", 64'(busy), 64'd0);

        // Reset during MAC at h=30, then a clean restart with new data.
        fill(20'h10000, 20'h00100, 20'h00000);
        start_run(11'd0);
        while (jc < 97) tick();
        chk("mid_rd", 64'({mce, msel, maddr}), 64'({1'b1, 3'b101, 17'd30}));
        reset = 1'b0;
        #1;
        chk("mid_rst", 64'({busy, mce, msel, maddr, o_valid, o_data, o_addr}), 64'd0);
        rd0 = reads;
        repeat (3) tick();
        chk("rst_quiet", 64'({mce, o_valid, busy}), 64'd0);
        chk("rst_reads", 64'(reads - rd0), 64'd0);
        reset = 1'b1;
        tick();
        fill(20'h30000, 20'h00100, 20'h00000);
        run_one("post", 20'h0C000);

        chk("proto", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
